regfile_write_arbiter: RTL and testbench
========================================

# regfile_write_arbiter

Shares the single register-file write port (RD_ADDRESS / RD_DATA / RD_WRITE_EN) between the in-order pipeline writeback stage and a long-latency result source (load/store unit, divider). The pipeline has fixed priority. Long-latency results queue in a small FIFO and drain into idle write slots. A starvation counter forces a one-cycle pipeline hold when the FIFO is blocked too long, and a hazard output flags reads of registers whose write is still queued.

## Interface
- REGISTER_WIDTH, 32, data width of a register.
- REGISTER_DEPTH, 32, number of architectural registers; address width AW = $clog2(REGISTER_DEPTH).
- FIFO_DEPTH, 4, long-latency result queue entries (power of two, ≥2).
- STARVE_LIMIT, 8, consecutive blocked cycles before a forced hold (≥1).

Ports:
- CLK  in  1  clock; all state updates on posedge.
- RST  in  1  asynchronous, active-high reset.
- PIPE_WB_VALID  in  1  pipeline writeback request this cycle.
- PIPE_WB_ADDRESS  in  AW  pipeline destination register.
- PIPE_WB_DATA  in  REGISTER_WIDTH  pipeline result.
- LSU_VALID  in  1  long-latency result offered.
- LSU_READY  out  1  FIFO can accept; push = LSU_VALID & LSU_READY.
- LSU_ADDRESS  in  AW  long-latency destination register.
- LSU_DATA  in  REGISTER_WIDTH  long-latency result.
- RS1_ADDRESS, RS2_ADDRESS  in  AW  decode-stage source registers for the hazard check.
- RS1_HAZARD, RS2_HAZARD  out  1  source has a write still queued/in flight from the LSU.
- PIPE_HOLD  out  1  registered; pipeline must freeze its writeback stage this cycle.
- RD_ADDRESS  out  AW  registered write address to the register file.
- RD_DATA  out  REGISTER_WIDTH  registered write data.
- RD_WRITE_EN  out  1  registered write enable.

## Operation
- Source select per cycle:
  - If PIPE_HOLD = 0 and PIPE_WB_VALID = 1, the pipeline wins.
  - Otherwise, if the FIFO is non-empty, the FIFO head is popped.
  - Otherwise the slot is idle.
- The winner is registered onto RD_*.
- Pipeline writes to address 0 produce RD_WRITE_EN = 0 but still consume the slot.
- LSU pushes to address 0 are accepted (READY honoured) and discarded, not enqueued.
- LSU_READY = !full & !RST. It is based on the current count only: no push when full, even if a pop occurs in the same cycle.
- Simultaneous push and pop when not full: count unchanged, order preserved (FIFO strict in-order).
- Arbiter states:
  - IDLE: FIFO empty.
  - DRAIN: non-empty, pipeline idle, pop.
  - BLOCKED: non-empty, pipeline wins; STARVE counter increments.
  - FORCE: PIPE_HOLD = 1, pop regardless of PIPE_WB_VALID.
- Transitions:
  - BLOCKED→FORCE when the counter reaches STARVE_LIMIT.
  - FORCE lasts exactly one cycle.
  - The counter clears on any pop or when the FIFO is empty.
- While PIPE_HOLD = 1, the pipeline holds its request; it is written in a later cycle (never dropped by this block).
- Hazard (combinational): RSx_HAZARD = RSx_ADDRESS ≠ 0 and it matches any valid FIFO entry, or the RD_* stage currently holds an LSU-sourced write to that address.
- Reset mid-operation discards queued entries; no write-back of partial state.

## Timing
- Reset values: RD_WRITE_EN 0, RD_ADDRESS 0, RD_DATA 0, PIPE_HOLD 0, LSU_READY 0 while RST high, RSx_HAZARD 0; FIFO count 0, STARVE counter 0.
- Pipeline latency: request sampled at edge N → RD_* valid after edge N; the register file commits at the following negedge.
- LSU latency: push at edge N; earliest appearance on RD_* after edge N+1 (no bypass).
- RSx_HAZARD asserts in the cycle after the push edge and deasserts after the edge that retires the entry's RD_* cycle.
- PIPE_HOLD rises after the edge at which the counter reaches STARVE_LIMIT and falls after the next edge.
- Guaranteed LSU service: a queued head waits at most STARVE_LIMIT+1 cycles.

## Test plan
- Reset, then idle: all outputs at reset values. After RST falls, LSU_READY = 1 and RD_WRITE_EN stays 0.
- Pipeline only: PIPE_WB x5 = 0x1234 at edge N → RD_ADDRESS 5, RD_DATA 0x1234, RD_WRITE_EN 1 after edge N. Address 0 → RD_WRITE_EN 0.
- LSU drain: push x7 = 0xAA at edge N with the pipeline idle → RD_* x7/0xAA after edge N+1. RS1_ADDRESS 7 → RS1_HAZARD high for cycles N+1..N+2, then low.
- Full FIFO: 4 pushes while the pipeline is valid every cycle → LSU_READY 0. A 5th offer is not accepted. Entries then drain in push order.
- Starvation: FIFO non-empty with PIPE_WB_VALID held high → PIPE_HOLD is high for exactly one cycle after 8 blocked cycles. The head is written that cycle, the held pipeline write lands next cycle, and the counter restarts.
- Async reset asserted with 3 queued entries → LSU_READY and RD_WRITE_EN 0 immediately, hazards clear, and no queued write appears after release.

Source files
------------

// File: rtl/regfile_write_arbiter.sv
// Register-file write-port arbiter: the pipeline writeback has priority, and
// long-latency (LSU/divider) results queue in a FIFO that drains into idle
// slots. A starvation counter forces a one-cycle pipeline hold.
module regfile_write_arbiter #(
  parameter int unsigned REGISTER_WIDTH = 32,
  parameter int unsigned REGISTER_DEPTH = 32,
  parameter int unsigned FIFO_DEPTH     = 4,
  parameter int unsigned STARVE_LIMIT   = 8,
  localparam int unsigned AW            = $clog2(REGISTER_DEPTH)
) (
  input  logic                      CLK,
  input  logic                      RST,
  input  logic                      PIPE_WB_VALID,
  input  logic [AW-1:0]             PIPE_WB_ADDRESS,
  input  logic [REGISTER_WIDTH-1:0] PIPE_WB_DATA,
  input  logic                      LSU_VALID,
  output logic                      LSU_READY,
  input  logic [AW-1:0]             LSU_ADDRESS,
  input  logic [REGISTER_WIDTH-1:0] LSU_DATA,
  input  logic [AW-1:0]             RS1_ADDRESS,
  input  logic [AW-1:0]             RS2_ADDRESS,
  output logic                      RS1_HAZARD,
  output logic                      RS2_HAZARD,
  output logic                      PIPE_HOLD,
  output logic [AW-1:0]             RD_ADDRESS,
  output logic [REGISTER_WIDTH-1:0] RD_DATA,
  output logic                      RD_WRITE_EN
);

  localparam int unsigned PW = $clog2(FIFO_DEPTH);
  localparam int unsigned CW = PW + 1;
  localparam int unsigned SW = $clog2(STARVE_LIMIT + 1);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_DRAIN,
    ST_BLOCKED,
    ST_FORCE
  } state_t;

  logic [AW-1:0]             fifo_addr [FIFO_DEPTH];
  logic [REGISTER_WIDTH-1:0] fifo_data [FIFO_DEPTH];
  logic [FIFO_DEPTH-1:0]     fifo_valid;
  logic [PW-1:0]             wr_ptr;
  logic [PW-1:0]             rd_ptr;
  logic [CW-1:0]             count;
  logic [CW-1:0]             count_next;
  logic [SW-1:0]             starve_cnt;
  logic [SW-1:0]             starve_next;
  state_t                    state;
  state_t                    state_next;
  logic                      rd_from_lsu;

  logic full;
  logic empty;
  logic accept;
  logic enq;
  logic pipe_win;
  logic pop;
  logic blocked;
  logic hold_next;

  assign full      = (count == CW'(FIFO_DEPTH));
  assign empty     = (count == '0);
  assign LSU_READY = !full && !RST;
  assign accept    = LSU_VALID && LSU_READY;
  // Writes to x0 are acknowledged but never queued.
  assign enq       = accept && (LSU_ADDRESS != '0);
  assign pipe_win  = (state != ST_FORCE) && PIPE_WB_VALID;
  assign pop       = !pipe_win && !empty;
  assign blocked   = pipe_win && !empty;

  // Next occupancy, starvation count and arbiter mode.
  always_comb begin
    count_next  = count + CW'(enq) - CW'(pop);
    starve_next = starve_cnt;
    hold_next   = 1'b0;
    state_next  = ST_IDLE;
    if (pop || empty) begin
      starve_next = '0;
    end else if (blocked) begin
      starve_next = starve_cnt + SW'(1);
    end
    hold_next = blocked && (starve_next == SW'(STARVE_LIMIT));
    if (hold_next) begin
      state_next = ST_FORCE;
    end else if (count_next == '0) begin
      state_next = ST_IDLE;
    end else if (blocked) begin
      state_next = ST_BLOCKED;
    end else begin
      state_next = ST_DRAIN;
    end
  end

  // Queue payload storage; occupancy is tracked by the valid bits.
  always_ff @(posedge CLK) begin
    if (enq) begin
      fifo_addr[wr_ptr] <= LSU_ADDRESS;
      fifo_data[wr_ptr] <= LSU_DATA;
    end
  end

  // Queue control, arbiter state and the registered write port.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      count       <= '0;
      fifo_valid  <= '0;
      starve_cnt  <= '0;
      state       <= ST_IDLE;
      PIPE_HOLD   <= 1'b0;
      RD_ADDRESS  <= '0;
      RD_DATA     <= '0;
      RD_WRITE_EN <= 1'b0;
      rd_from_lsu <= 1'b0;
    end else begin
      count      <= count_next;
      starve_cnt <= starve_next;
      state      <= state_next;
      PIPE_HOLD  <= hold_next;
      if (enq) begin
        wr_ptr             <= wr_ptr + PW'(1);
        fifo_valid[wr_ptr] <= 1'b1;
      end
      if (pop) begin
        rd_ptr             <= rd_ptr + PW'(1);
        fifo_valid[rd_ptr] <= 1'b0;
      end
      if (pipe_win) begin
        RD_ADDRESS  <= PIPE_WB_ADDRESS;
        RD_DATA     <= PIPE_WB_DATA;
        RD_WRITE_EN <= (PIPE_WB_ADDRESS != '0);
        rd_from_lsu <= 1'b0;
      end else if (pop) begin
        RD_ADDRESS  <= fifo_addr[rd_ptr];
        RD_DATA     <= fifo_data[rd_ptr];
        RD_WRITE_EN <= 1'b1;
        rd_from_lsu <= 1'b1;
      end else begin
        RD_WRITE_EN <= 1'b0;
        rd_from_lsu <= 1'b0;
      end
    end
  end

  // Source-register hazards against queued and in-flight LSU writes.
  always_comb begin
    RS1_HAZARD = rd_from_lsu && (RD_ADDRESS == RS1_ADDRESS);
    RS2_HAZARD = rd_from_lsu && (RD_ADDRESS == RS2_ADDRESS);
    for (int unsigned i = 0; i < FIFO_DEPTH; i++) begin
      if (fifo_valid[i] && (fifo_addr[i] == RS1_ADDRESS)) RS1_HAZARD = 1'b1;
      if (fifo_valid[i] && (fifo_addr[i] == RS2_ADDRESS)) RS2_HAZARD = 1'b1;
    end
    if (RS1_ADDRESS == '0) RS1_HAZARD = 1'b0;
    if (RS2_ADDRESS == '0) RS2_HAZARD = 1'b0;
  end

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Directed bench for regfile_write_arbiter with hand-computed expectations.
module tb_regfile_write_arbiter;

  logic        CLK = 1'b0;
  logic        RST;
  logic        PIPE_WB_VALID;
  logic [4:0]  PIPE_WB_ADDRESS;
  logic [31:0] PIPE_WB_DATA;
  logic        LSU_VALID;
  logic        LSU_READY;
  logic [4:0]  LSU_ADDRESS;
  logic [31:0] LSU_DATA;
  logic [4:0]  RS1_ADDRESS;
  logic [4:0]  RS2_ADDRESS;
  logic        RS1_HAZARD;
  logic        RS2_HAZARD;
  logic        PIPE_HOLD;
  logic [4:0]  RD_ADDRESS;
  logic [31:0] RD_DATA;
  logic        RD_WRITE_EN;

  int checks = 0;
  int errors = 0;

  regfile_write_arbiter dut (
    .CLK(CLK), .RST(RST),
    .PIPE_WB_VALID(PIPE_WB_VALID), .PIPE_WB_ADDRESS(PIPE_WB_ADDRESS), .PIPE_WB_DATA(PIPE_WB_DATA),
    .LSU_VALID(LSU_VALID), .LSU_READY(LSU_READY), .LSU_ADDRESS(LSU_ADDRESS), .LSU_DATA(LSU_DATA),
    .RS1_ADDRESS(RS1_ADDRESS), .RS2_ADDRESS(RS2_ADDRESS),
    .RS1_HAZARD(RS1_HAZARD), .RS2_HAZARD(RS2_HAZARD), .PIPE_HOLD(PIPE_HOLD),
    .RD_ADDRESS(RD_ADDRESS), .RD_DATA(RD_DATA), .RD_WRITE_EN(RD_WRITE_EN)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Sample 1 time unit after the rising edge.
  task automatic tick;
    @(posedge CLK);
    #1;
  endtask

  task automatic check_rd(input string tag, input logic en, input logic [4:0] a, input logic [31:0] d);
    check({tag, "_en"}, 64'(RD_WRITE_EN), 64'(en));
    if (en) begin
      check({tag, "_addr"}, 64'(RD_ADDRESS), 64'(a));
      check({tag, "_data"}, 64'(RD_DATA), 64'(d));
    end
  endtask

  initial begin
    RST = 1'b1;
    PIPE_WB_VALID = 1'b0; PIPE_WB_ADDRESS = '0; PIPE_WB_DATA = '0;
    LSU_VALID = 1'b0; LSU_ADDRESS = '0; LSU_DATA = '0;
    RS1_ADDRESS = 5'd5; RS2_ADDRESS = 5'd0;

    // Reset values
    #2;
    check("rst_en", 64'(RD_WRITE_EN), 64'd0);
    check("rst_addr", 64'(RD_ADDRESS), 64'd0);
    check("rst_data", 64'(RD_DATA), 64'd0);
    check("rst_hold", 64'(PIPE_HOLD), 64'd0);
    check("rst_ready", 64'(LSU_READY), 64'd0);
    check("rst_haz1", 64'(RS1_HAZARD), 64'd0);
    tick; tick;
    check("rst_en_clk", 64'(RD_WRITE_EN), 64'd0);
    RST = 1'b0;
    #1;
    check("rel_ready", 64'(LSU_READY), 64'd1);
    tick;
    check_rd("rel_idle", 1'b0, '0, '0);

    // Pipeline-only writes, including x0
    PIPE_WB_VALID = 1'b1; PIPE_WB_ADDRESS = 5'd5; PIPE_WB_DATA = 32'h1234;
    tick;
    check_rd("pipe_x5", 1'b1, 5'd5, 32'h1234);
    check("pipe_nohaz", 64'(RS1_HAZARD), 64'd0);
    PIPE_WB_ADDRESS = 5'd0; PIPE_WB_DATA = 32'h9;
    tick;
    check_rd("pipe_x0", 1'b0, '0, '0);
    PIPE_WB_VALID = 1'b0;
    tick;
    check_rd("pipe_idle", 1'b0, '0, '0);

    // LSU drain into an idle slot and hazard window
    LSU_VALID = 1'b1; LSU_ADDRESS = 5'd7; LSU_DATA = 32'hAA;
    RS1_ADDRESS = 5'd7; RS2_ADDRESS = 5'd7;
    #1;
    check("lsu_haz_pre", 64'(RS1_HAZARD), 64'd0);
    tick;
    LSU_VALID = 1'b0;
    #1;
    check_rd("lsu_n", 1'b0, '0, '0);
    check("lsu_haz_n1", 64'(RS1_HAZARD), 64'd1);
    tick;
    check_rd("lsu_n1", 1'b1, 5'd7, 32'hAA);
    check("lsu_haz_n2", 64'(RS1_HAZARD), 64'd1);
    check("lsu_haz2_n2", 64'(RS2_HAZARD), 64'd1);
    tick;
    check_rd("lsu_n2", 1'b0, '0, '0);
    check("lsu_haz_clr", 64'(RS1_HAZARD), 64'd0);

    // LSU write to x0 is accepted and discarded
    LSU_VALID = 1'b1; LSU_ADDRESS = 5'd0; LSU_DATA = 32'h55;
    #1;
    check("x0_ready", 64'(LSU_READY), 64'd1);
    tick;
    LSU_VALID = 1'b0;
    tick;
    check_rd("x0_drop1", 1'b0, '0, '0);
    tick;
    check_rd("x0_drop2", 1'b0, '0, '0);

    // Fill the FIFO while the pipeline owns every slot
    PIPE_WB_VALID = 1'b1; PIPE_WB_ADDRESS = 5'd1;
    RS2_ADDRESS = 5'd13;
    for (int i = 0; i < 4; i++) begin
      PIPE_WB_DATA = 32'h100 + 32'(i);
      LSU_VALID = 1'b1; LSU_ADDRESS = 5'd10 + 5'(i); LSU_DATA = 32'hB0 + 32'(i);
      #1;
      check("full_ready_pre", 64'(LSU_READY), 64'd1);
      tick;
      check_rd("full_pipe", 1'b1, 5'd1, 32'h100 + 32'(i));
    end
    LSU_ADDRESS = 5'd14; LSU_DATA = 32'hBF;
    #1;
    check("full_ready", 64'(LSU_READY), 64'd0);
    check("full_haz13", 64'(RS2_HAZARD), 64'd1);
    RS2_ADDRESS = 5'd14;
    #1;
    check("full_haz14", 64'(RS2_HAZARD), 64'd0);
    tick;
    LSU_VALID = 1'b0; PIPE_WB_VALID = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick;
      check_rd("full_drain", 1'b1, 5'd10 + 5'(i), 32'hB0 + 32'(i));
    end
    tick;
    check_rd("full_empty", 1'b0, '0, '0);
    check("full_ready_back", 64'(LSU_READY), 64'd1);

    // Starvation: two queued entries behind a continuously valid pipeline
    PIPE_WB_VALID = 1'b1; PIPE_WB_ADDRESS = 5'd3; PIPE_WB_DATA = 32'h3333;
    LSU_VALID = 1'b1; LSU_ADDRESS = 5'd20; LSU_DATA = 32'hC0;
    tick;
    check_rd("stv_p1", 1'b1, 5'd3, 32'h3333);
    LSU_ADDRESS = 5'd21; LSU_DATA = 32'hC1;
    tick;
    LSU_VALID = 1'b0;
    check_rd("stv_p2", 1'b1, 5'd3, 32'h3333);
    check("stv_hold_b1", 64'(PIPE_HOLD), 64'd0);
    for (int i = 2; i <= 8; i++) begin
      tick;
      check("stv_hold_a", 64'(PIPE_HOLD), 64'(i == 8));
      check_rd("stv_blk_a", 1'b1, 5'd3, 32'h3333);
    end
    tick;
    check("stv_force_end_a", 64'(PIPE_HOLD), 64'd0);
    check_rd("stv_head_a", 1'b1, 5'd20, 32'hC0);
    for (int i = 1; i <= 8; i++) begin
      tick;
      check("stv_hold_b", 64'(PIPE_HOLD), 64'(i == 8));
      check_rd("stv_blk_b", 1'b1, 5'd3, 32'h3333);
    end
    tick;
    check("stv_force_end_b", 64'(PIPE_HOLD), 64'd0);
    check_rd("stv_head_b", 1'b1, 5'd21, 32'hC1);
    tick;
    check_rd("stv_pipe_after", 1'b1, 5'd3, 32'h3333);
    check("stv_hold_after", 64'(PIPE_HOLD), 64'd0);
    PIPE_WB_VALID = 1'b0;
    tick;
    check_rd("stv_idle", 1'b0, '0, '0);

    // Asynchronous reset with three queued entries
    PIPE_WB_VALID = 1'b1; PIPE_WB_ADDRESS = 5'd4; PIPE_WB_DATA = 32'h4444;
    for (int i = 0; i < 3; i++) begin
      LSU_VALID = 1'b1; LSU_ADDRESS = 5'd25 + 5'(i); LSU_DATA = 32'hE0 + 32'(i);
      tick;
    end
    LSU_VALID = 1'b0;
    RS1_ADDRESS = 5'd25; RS2_ADDRESS = 5'd27;
    #1;
    check_rd("ar_pipe", 1'b1, 5'd4, 32'h4444);
    check("ar_haz1_pre", 64'(RS1_HAZARD), 64'd1);
    check("ar_haz2_pre", 64'(RS2_HAZARD), 64'd1);
    #2;
    RST = 1'b1;
    #1;
    check("ar_ready", 64'(LSU_READY), 64'd0);
    check("ar_en", 64'(RD_WRITE_EN), 64'd0);
    check("ar_addr", 64'(RD_ADDRESS), 64'd0);
    check("ar_haz1", 64'(RS1_HAZARD), 64'd0);
    check("ar_haz2", 64'(RS2_HAZARD), 64'd0);
    check("ar_hold", 64'(PIPE_HOLD), 64'd0);
    PIPE_WB_VALID = 1'b0;
    tick; tick;
    RST = 1'b0;
    for (int i = 0; i < 6; i++) begin
      tick;
      check_rd("ar_no_replay", 1'b0, '0, '0);
    end
    check("ar_ready_back", 64'(LSU_READY), 64'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
